// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S constants and stereo sample type
package i2s_pkg;

  localparam int I2S_SAMPLE_W = 24;
  localparam int I2S_SLOT_W   = 32;

  typedef struct packed {
    logic [I2S_SAMPLE_W-1:0] left;
    logic [I2S_SAMPLE_W-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - enable-style bit clock divider
// Produces a registered BCLK plus one-clk fall/rise strobes from a free-running counter.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_en,
  output logic rise_en
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCLK_DIV / 2 - 1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_bclk;

  // Strobes fire on the clk edge where the counter leaves these values.
  assign fall_en    = (r_div == DIV_LAST);
  assign rise_en    = (r_div == DIV_RISE);
  assign w_div_next = fall_en ? '0 : r_div + 1'b1;
  assign bclk       = r_bclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_bclk <= (w_div_next >= DIV_HALF);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter: frame counter, holding buffer and serializer
// One stereo pair per frame; an empty buffer at frame start sends zeros and pulses underrun.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int SAMPLE_W = I2S_SAMPLE_W,
  parameter int SLOT_W   = I2S_SLOT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int T_W     = $clog2(FRAME_W);
  localparam logic [T_W-1:0] T_LAST  = T_W'(FRAME_W - 1);
  localparam logic [T_W-1:0] T_LR_LO = T_W'(SLOT_W - 1);
  localparam logic [T_W-1:0] T_LR_HI = T_W'(FRAME_W - 2);

  logic               w_fall;
  logic               w_rise;
  logic               w_load;
  logic               w_accept;
  logic               w_lr_next;
  logic [T_W-1:0]     w_t_next;
  logic [FRAME_W-1:0] w_frame;

  logic [T_W-1:0]      r_t;
  logic                r_lrclk;
  logic [FRAME_W-1:0]  r_shift;
  logic                r_full;
  logic [SAMPLE_W-1:0] r_buf_left;
  logic [SAMPLE_W-1:0] r_buf_right;
  logic                r_underrun;

  i2s_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk     (clk),
    .rst     (rst),
    .bclk    (bclk),
    .fall_en (w_fall),
    .rise_en (w_rise)
  );

  assign w_load    = w_fall && (r_t == T_LAST);
  assign w_accept  = s_valid && !r_full;
  assign w_t_next  = (r_t == T_LAST) ? '0 : r_t + 1'b1;
  // Word select leads the MSB of each slot by one bit time.
  assign w_lr_next = (w_t_next >= T_LR_LO) && (w_t_next <= T_LR_HI);

  always_comb begin
    w_frame = '0;
    if (r_full) begin
      w_frame[FRAME_W-1 -: SAMPLE_W] = r_buf_left;
      w_frame[SLOT_W-1  -: SAMPLE_W] = r_buf_right;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t        <= T_LAST;
      r_lrclk    <= 1'b0;
      r_shift    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_full;
      if (w_fall) begin
        r_t     <= w_t_next;
        r_lrclk <= w_lr_next;
        r_shift <= w_load ? w_frame : (r_shift << 1);
      end
    end
  end

  // Accept only into an empty buffer, so it can never collide with a load that empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= 1'b0;
      r_buf_left  <= '0;
      r_buf_right <= '0;
    end else if (w_accept) begin
      r_full      <= 1'b1;
      r_buf_left  <= s_left;
      r_buf_right <= s_right;
    end else if (w_load) begin
      r_full      <= 1'b0;
    end
  end

  assign s_ready  = !r_full;
  assign lrclk    = r_lrclk;
  assign sdata    = r_shift[FRAME_W-1];
  assign underrun = r_underrun;

  a_strobes_exclusive : assert property (@(posedge clk) disable iff (rst) !(w_fall && w_rise));

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - self-checking bench for i2s_tx against a bit-time reference model
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DIV = 4;
  localparam int SW  = I2S_SAMPLE_W;
  localparam int SL  = I2S_SLOT_W;
  localparam int FW  = 2 * SL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  logic          bclk, lrclk, sdata, underrun;

  int checks = 0;
  int failures = 0;

  i2s_tx #(.BCLK_DIV(DIV), .SAMPLE_W(SW), .SLOT_W(SL)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_bit(input int t, input logic [SW-1:0] l, input logic [SW-1:0] r);
    if (t < SW) return l[SW-1-t];
    if (t >= SL && t < SL + SW) return r[SW-1-(t-SL)];
    return 1'b0;
  endfunction

  function automatic logic [FW-1:0] frame_word(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [FW-1:0] w;
    for (int t = 0; t < FW; t++) w[FW-1-t] = exp_bit(t, l, r);
    return w;
  endfunction

  function automatic logic [FW-1:0] lr_word();
    logic [FW-1:0] w;
    for (int t = 0; t < FW; t++) w[FW-1-t] = (t >= SL-1 && t <= FW-2);
    return w;
  endfunction

  // Reference model: advanced once per clk from bit-time arithmetic.
  int            m_n = 0;
  int            m_t = FW - 1;
  bit            m_full = 0, m_bclk = 0, m_lr = 0, m_sd = 0, m_ur = 0, m_fall, m_rdy;
  logic [SW-1:0] m_bl = '0, m_br = '0, m_fl = '0, m_fr = '0;
  int            d_acc = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_n = 0; m_t = FW - 1; m_full = 0;
        m_bl = '0; m_br = '0; m_fl = '0; m_fr = '0;
        m_bclk = 0; m_lr = 0; m_sd = 0; m_ur = 0;
      end else begin
        m_rdy = !m_full;
        if (s_valid && s_ready) d_acc++;
        m_n++;
        m_fall = (m_n % DIV) == 0;
        m_bclk = (m_n % DIV) >= DIV / 2;
        m_ur = 0;
        if (m_fall && m_t == FW - 1) begin
          if (m_full) begin
            m_fl = m_bl; m_fr = m_br; m_full = 0;
          end else begin
            m_fl = '0; m_fr = '0; m_ur = 1;
          end
        end
        if (s_valid && m_rdy) begin
          m_full = 1; m_bl = s_left; m_br = s_right;
        end
        if (m_fall) begin
          m_t = (m_t + 1) % FW;
          m_lr = (m_t >= SL - 1) && (m_t <= FW - 2);
          m_sd = exp_bit(m_t, m_fl, m_fr);
        end
      end
    end
  end

  // Per-clk output checks plus frame capture on each BCLK rise.
  bit            seen0 = 0, prev_bclk = 0;
  logic [FW-1:0] cap_sd = '0, cap_lr = '0, last_sd = '0, last_lr = '0;
  int            cap_frames = 0;
  int            ur_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen0 = 0; prev_bclk = 0;
      end else begin
        check_eq("bclk", bclk, m_bclk);
        check_eq("lrclk", lrclk, m_lr);
        check_eq("sdata", sdata, m_sd);
        check_eq("s_ready", s_ready, !m_full);
        check_eq("underrun", underrun, m_ur);
        if (underrun) ur_cnt++;
        if (m_bclk && !prev_bclk) begin
          if (m_t == 0) seen0 = 1;
          cap_sd[FW-1-m_t] = sdata;
          cap_lr[FW-1-m_t] = lrclk;
          if (m_t == FW - 1 && seen0) begin
            last_sd = cap_sd; last_lr = cap_lr; cap_frames++;
          end
        end
        prev_bclk = m_bclk;
      end
    end
  end

  task automatic wait_frame();
    int  f0 = cap_frames;
    bit  ok = 0;
    for (int i = 0; i < 3 * FW * DIV; i++) begin
      @(negedge clk);
      if (cap_frames != f0) begin ok = 1; break; end
    end
    check_eq("wait_frame", ok, 1);
  endtask

  task automatic wait_t(input int t, input bit pre_load);
    bit ok = 0;
    for (int i = 0; i < 2 * FW * DIV; i++) begin
      @(negedge clk);
      if (m_t == t && (!pre_load || (m_n % DIV) == DIV - 1)) begin ok = 1; break; end
    end
    check_eq("wait_t", ok, 1);
  endtask

  task automatic underrun_latency(input string tag);
    int k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (underrun) begin k = i; break; end
    end
    check_eq(tag, k, DIV);
  endtask

  initial begin
    logic [SW-1:0] pl, pr, al, ar;
    bit            pend;
    int            a0, u0;

    // Reset state
    repeat (5) @(negedge clk);
    check_eq("rst_bclk", bclk, 0);
    check_eq("rst_lrclk", lrclk, 0);
    check_eq("rst_sdata", sdata, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_ready", s_ready, 1);

    // Idle start: first load underruns BCLK_DIV clks after release
    rst = 1'b0;
    underrun_latency("idle_ur_lat");

    // Single frame queued during the idle frame
    s_left = 24'hA5A5A5; s_right = 24'h5A5A5A; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    wait_frame();
    check_eq("idle_sd", last_sd, 64'h0);
    check_eq("idle_lr", last_lr, lr_word());
    wait_frame();
    check_eq("single_sd", last_sd, {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00});
    check_eq("single_lr", last_lr, 64'h0000_0001_FFFF_FFFE);

    // Back-to-back with incrementing pairs
    s_left = SW'($urandom); s_right = SW'($urandom); s_valid = 1'b1; pend = 0;
    for (int c = 0; c < 300 + 4 * FW * DIV; c++) begin
      if (c == 300) begin a0 = d_acc; u0 = ur_cnt; end
      @(negedge clk);
      if (pend) begin s_left = s_left + 1'b1; s_right = s_right + 1'b1; end
      pend = s_ready;
    end
    check_eq("b2b_accepts", d_acc - a0, 4);
    check_eq("b2b_underruns", ur_cnt - u0, 0);
    s_valid = 1'b0;
    repeat (3) wait_frame();

    // Accept on the very edge of a load with an empty buffer
    wait_t(FW - 1, 1);
    pl = SW'($urandom); pr = SW'($urandom);
    s_left = pl; s_right = pr; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check_eq("sim_ur", underrun, 1);
    check_eq("sim_ready", s_ready, 0);
    wait_frame();
    check_eq("sim_zero_sd", last_sd, 64'h0);
    wait_frame();
    check_eq("sim_next_sd", last_sd, frame_word(pl, pr));

    // Backpressure: second pair offered while the buffer is full
    wait_t(2, 0);
    al = SW'($urandom); ar = SW'($urandom);
    s_left = al; s_right = ar; s_valid = 1'b1;
    @(negedge clk);
    s_left = ~al; s_right = ~ar;
    repeat (50) @(negedge clk);
    check_eq("bp_ready", s_ready, 0);
    s_valid = 1'b0;
    wait_frame();
    wait_frame();
    check_eq("bp_sd", last_sd, frame_word(al, ar));

    // Reset mid-frame with a pair pending
    wait_t(10, 0);
    s_left = SW'($urandom) | 24'h800001; s_right = SW'($urandom); s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    wait_t(40, 0);
    check_eq("pre_rst_lrclk", lrclk, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_bclk", bclk, 0);
    check_eq("mid_rst_lrclk", lrclk, 0);
    check_eq("mid_rst_sdata", sdata, 0);
    check_eq("mid_rst_ready", s_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    underrun_latency("rst_ur_lat");
    wait_frame();
    check_eq("rst_discard_sd", last_sd, 64'h0);
    check_eq("rst_lr", last_lr, lr_word());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
